// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode: a DEPTH-entry FIFO of {pc, inst} pairs with flush.
// Define INST_QUEUE_BYPASS_EN to let an empty queue pass the fetch input straight to decode.
module inst_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_inst,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_inst,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [31:0]    NOP_INST = 32'h0000_0013;

  logic [63:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             q_valid;
  logic             bypass;
  logic             push;
  logic             pop;

  assign q_valid  = (count_q != '0);
  assign in_ready = (count_q < FULL_CNT);
  assign count    = count_q;

`ifdef INST_QUEUE_BYPASS_EN
  // Gated by rst_n so the output stays invalid while reset is held.
  assign bypass = rst_n & ~flush & in_valid & ~q_valid;
`else
  assign bypass = 1'b0;
`endif

  assign pop  = q_valid & out_ready & ~flush;
  // A bypassed entry that decode takes this cycle never enters storage.
  assign push = in_valid & in_ready & ~flush & ~(bypass & out_ready);

  always_comb begin
    out_valid = q_valid | bypass;
    out_pc    = 32'h0;
    out_inst  = NOP_INST;
    if (q_valid) begin
      out_pc   = mem[rd_ptr_q][63:32];
      out_inst = mem[rd_ptr_q][31:0];
    end else if (bypass) begin
      out_pc   = in_pc;
      out_inst = in_inst;
    end
  end

  // Storage is deliberately not reset; it is only visible while count is nonzero.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= {in_pc, in_inst};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop) begin
        count_q <= count_q + (PTR_W + 1)'(1);
      end else if (pop && !push) begin
        count_q <= count_q - (PTR_W + 1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// Directed self-checking bench for inst_queue (DEPTH = 4).
module tb_inst_queue;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [2:0]  count;

  int checks;
  int failures;

  inst_queue #(.DEPTH(4), .PTR_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_inst   (in_inst),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_inst  (out_inst),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_n(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_pc    = base + 32'(4 * i);
      in_inst  = 32'h1000 + 32'(i);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_inst = '0;
    #3;
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_inst !== NOP) begin failures++; $display("FAIL reset_out_inst got=%h exp=%h", out_inst, NOP); end
    checks++; if (out_pc !== 32'h0) begin failures++; $display("FAIL reset_out_pc got=%h exp=0", out_pc); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    #9 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [31:0] pcs [3];
    logic [31:0] insts [3];
    pcs   = '{32'h0, 32'h4, 32'h8};
    insts = '{32'h0050_0093, 32'h00A0_0113, 32'h0020_81B3};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_pc = pcs[i]; in_inst = insts[i];
`ifndef INST_QUEUE_BYPASS_EN
      if (i == 0) begin
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_latency got=%b exp=0", out_valid); end
      end
`endif
      tick();
`ifndef INST_QUEUE_BYPASS_EN
      checks++; if (out_pc !== pcs[i]) begin failures++; $display("FAIL basic_pc%0d got=%h exp=%h", i, out_pc, pcs[i]); end
      checks++; if (out_inst !== insts[i]) begin failures++; $display("FAIL basic_inst%0d got=%h exp=%h", i, out_inst, insts[i]); end
      checks++; if (count !== 3'd1) begin failures++; $display("FAIL basic_count%0d got=%0d exp=1", i, count); end
`endif
    end
    in_valid = 1'b0;
    tick();
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL basic_drain_count got=%0d exp=0", count); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_drain_valid got=%b exp=0", out_valid); end
    checks++; if (out_inst !== NOP) begin failures++; $display("FAIL basic_drain_nop got=%h exp=%h", out_inst, NOP); end
  endtask

  task automatic test_full();
    logic [31:0] exp_pc [5];
    logic        accepted;
    exp_pc = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_pc = exp_pc[i]; in_inst = 32'h2000 + 32'(i);
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL full_in_ready%0d got=%b exp=1", i, in_ready); end
      tick();
    end
    in_pc = 32'h10; in_inst = 32'h2004;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_in_ready_low got=%b exp=0", in_ready); end
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL full_count got=%0d exp=4", count); end
    tick();
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL full_hold_count got=%0d exp=4", count); end
    checks++; if (out_pc !== 32'h0) begin failures++; $display("FAIL full_stable_pc got=%h exp=0", out_pc); end
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_pc !== exp_pc[k]) begin
        failures++; $display("FAIL full_order%0d got=%b/%h exp=1/%h", k, out_valid, out_pc, exp_pc[k]);
      end
      accepted = in_valid & in_ready;
      tick();
      if (accepted) in_valid = 1'b0;
    end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL full_drain_count got=%0d exp=0", count); end
    out_ready = 1'b0;
  endtask

  task automatic test_full_push_pop();
    logic [31:0] rest [3];
    rest = '{32'h108, 32'h10C, 32'h200};
    out_ready = 1'b0;
    push_n(4, 32'h100);
    in_valid = 1'b1; in_pc = 32'h200; in_inst = 32'h3000; out_ready = 1'b1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL pp_full_ready got=%b exp=0", in_ready); end
    tick();
    checks++; if (count !== 3'd3) begin failures++; $display("FAIL pp_count1 got=%0d exp=3", count); end
    checks++; if (out_pc !== 32'h104) begin failures++; $display("FAIL pp_pc1 got=%h exp=104", out_pc); end
    tick();
    in_valid = 1'b0;
    checks++; if (count !== 3'd3) begin failures++; $display("FAIL pp_count2 got=%0d exp=3", count); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (out_pc !== rest[k]) begin failures++; $display("FAIL pp_order%0d got=%h exp=%h", k, out_pc, rest[k]); end
      tick();
    end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL pp_drain got=%0d exp=0", count); end
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    push_n(3, 32'h300);
    flush = 1'b1; in_valid = 1'b1; in_pc = 32'h400; in_inst = 32'h4000;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL flush_count got=%0d exp=0", count); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
    checks++; if (out_inst !== NOP) begin failures++; $display("FAIL flush_nop got=%h exp=%h", out_inst, NOP); end
    tick();
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL flush_not_stored got=%0d exp=0", count); end
    push_n(1, 32'h500);
    checks++; if (out_pc !== 32'h500) begin failures++; $display("FAIL flush_repush got=%h exp=500", out_pc); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    push_n(2, 32'h600);
    checks++; if (count !== 3'd2) begin failures++; $display("FAIL ar_pre_count got=%0d exp=2", count); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL ar_count got=%0d exp=0", count); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ar_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL ar_in_ready got=%b exp=1", in_ready); end
    tick();
    #2 rst_n = 1'b1;
    tick();
    push_n(1, 32'h700);
    checks++; if (out_pc !== 32'h700 || count !== 3'd1) begin
      failures++; $display("FAIL ar_first_push got=%h/%0d exp=700/1", out_pc, count);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

`ifdef INST_QUEUE_BYPASS_EN
  task automatic test_bypass();
    out_ready = 1'b1; in_valid = 1'b1; in_pc = 32'h800; in_inst = 32'hFFF0_0093;
    #1;
    checks++; if (out_valid !== 1'b1 || out_inst !== 32'hFFF0_0093) begin
      failures++; $display("FAIL bypass_out got=%b/%h exp=1/fff00093", out_valid, out_inst);
    end
    tick();
    in_valid = 1'b0;
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL bypass_count got=%0d exp=0", count); end
    out_ready = 1'b0;
  endtask
`endif

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_full();
    test_full_push_pop();
    test_flush();
    test_async_reset();
`ifdef INST_QUEUE_BYPASS_EN
    test_bypass();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_queue.md
INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of instruction entries held; power of two, at least 2.
REQ-002 SHALL have parameter PTR_W, default 2, pointer width, equal to log2(DEPTH).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port flush, input, 1, synchronous discard of all queued instructions on branch/jump redirect.
REQ-006 SHALL have port in_valid, input, 1, fetch stage presents an instruction.
REQ-007 SHALL have port in_ready, output, 1, queue accepts an instruction this cycle.
REQ-008 SHALL have port in_pc, input, 32, PC of the presented instruction.
REQ-009 SHALL have port in_inst, input, 32, the presented instruction word.
REQ-010 SHALL have port out_valid, output, 1, decode stage is offered an instruction.
REQ-011 SHALL have port out_ready, input, 1, decode stage consumes the offered instruction.
REQ-012 SHALL have port out_pc, output, 32, PC of the offered instruction.
REQ-013 SHALL have port out_inst, output, 32, offered instruction word; bits [31:7] feed immediate extension.
REQ-014 SHALL have port count, output, PTR_W+1, number of occupied entries.

Function
REQ-015 SHALL store {in_pc, in_inst} as a FIFO: circular write pointer, read pointer and occupancy counter; pointers wrap from DEPTH-1 to 0.
REQ-016 SHALL drive in_ready = (count < DEPTH), from registered state only, with no combinational dependence on out_ready or in_valid.
REQ-017 SHALL push when in_valid & in_ready & ~flush: write the entry, advance the write pointer, count +1.
REQ-018 SHALL pop when out_valid & out_ready & ~flush: advance the read pointer, count -1.
REQ-019 SHALL, on simultaneous push and pop, advance both pointers and leave count unchanged.
REQ-020 SHALL, when full (count == DEPTH), hold in_ready = 0; a same-cycle pop frees a slot only from the next cycle.
REQ-021 SHALL drive out_valid = (count != 0) and out_pc/out_inst from the read-pointer entry; latency from push to out_valid is 1 cycle.
REQ-022 SHALL drive out_inst = 32'h00000013 (NOP) and out_pc = 32'h0 whenever out_valid = 0.
REQ-023 SHALL, on flush, set count, write pointer and read pointer to 0 at the next edge and ignore any same-cycle push or pop.
REQ-024 SHALL keep out_pc/out_inst stable while out_valid = 1 and out_ready = 0.
REQ-025 SHALL not reorder, duplicate or drop any accepted entry, except on flush or reset.

Reset
REQ-026 SHALL, while rst_n = 0, force count = 0, both pointers = 0, out_valid = 0, out_inst = 32'h00000013, out_pc = 0 and in_ready = 1, independent of clk.
REQ-027 SHALL not reset the storage array; its contents are never visible while invalid.
REQ-028 SHALL discard any in-flight entries when reset is asserted mid-operation; the first push after rst_n rises is the first entry offered.

Configuration
REQ-029 SHALL support macro INST_QUEUE_BYPASS_EN.
REQ-030 SHALL, with INST_QUEUE_BYPASS_EN defined, when count == 0 and in_valid = 1 and flush = 0, drive out_valid = 1 and out_pc/out_inst = in_pc/in_inst combinationally.
REQ-031 SHALL, in that bypass case, with out_ready = 1, not store the entry (count stays 0); with out_ready = 0, store the entry as a normal push.
REQ-032 SHALL, without INST_QUEUE_BYPASS_EN, implement no input-to-output combinational path; latency is exactly 1 cycle.

Verification
REQ-033 SHALL pass this scenario: reset, then push pc 0x0/0x4/0x8 with inst 0x00500093/0x00A00113/0x002081B3 and out_ready = 1 -> same order on the output, each 1 cycle after push (bypass off), count returns to 0.
REQ-034 SHALL pass this scenario: out_ready = 0, push 5 entries with DEPTH = 4 -> in_ready falls after the 4th, count = 4, the 5th is held by fetch; raise out_ready -> pc order 0x0, 0x4, 0x8, 0xC, 0x10.
REQ-035 SHALL pass this scenario: full queue with push and pop in the same cycle -> push rejected, count 3; next cycle push and pop both accepted, count stays 3.
REQ-036 SHALL pass this scenario: 3 entries queued, flush = 1 with in_valid = 1 in the same cycle -> next cycle count = 0, out_valid = 0, out_inst = 0x00000013, flushed-cycle input not stored.
REQ-037 SHALL pass this scenario: rst_n low mid-stream with count = 2 -> out_valid = 0 and count = 0 immediately, without a clock edge.
REQ-038 SHALL pass this scenario: with INST_QUEUE_BYPASS_EN, empty queue, in_valid = 1, in_inst = 0xFFF00093, out_ready = 1 -> out_valid = 1 and out_inst = 0xFFF00093 in the same cycle, count stays 0.
